// File: rtl/hyperram_responder.sv
// hyperram_responder
//   HyperBus responder (device side) modelled in the clk domain. It
//   oversamples hr_ck, decodes the 48-bit command/address, applies a fixed
//   doubled initial latency, and serves linear read/write bursts from an
//   internal 2^AW x 16-bit array stored as two byte lanes.
//
//   Optional feature macro: HYPERRAM_RESP_REGS_EN
//     defined   -> ID0/ID1/CR0 register space is implemented
//     undefined -> register reads return 0, register writes are discarded
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   hr_rst_l          device reset (active-low), same effect as rst
//   hr_cs_l, hr_ck    chip select (active-low) and HyperBus clock
//   hr_dq_in/out      DQ byte lane, hr_dq_oe_l output enable (active-low)
//   hr_rwds_in        write byte mask (1 = masked)
//   hr_rwds_out       latency indicator in CA, read strobe in READ
//   hr_rwds_oe_l      RWDS output enable (active-low)
module hyperram_responder #(
  parameter int AW  = 10,
  parameter int LAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hr_rst_l,
  input  logic       hr_cs_l,
  input  logic       hr_ck,
  input  logic [7:0] hr_dq_in,
  output logic [7:0] hr_dq_out,
  output logic       hr_dq_oe_l,
  input  logic       hr_rwds_in,
  output logic       hr_rwds_out,
  output logic       hr_rwds_oe_l
);

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LATENCY, S_WRITE, S_READ} state_t;

  localparam int CW    = $clog2(2 * LAT + 6);
  localparam int DEPTH = 1 << AW;

  // Input sampling stage; r_ck_d is the delayed copy used for edge detect.
  logic       r_rst_l, r_cs_l, r_ck, r_ck_d, r_rwds;
  logic [7:0] r_dq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_l <= 1'b1;
      r_cs_l  <= 1'b1;
      r_ck    <= 1'b0;
      r_ck_d  <= 1'b0;
      r_dq    <= 8'h00;
      r_rwds  <= 1'b1;
    end else begin
      r_rst_l <= hr_rst_l;
      r_cs_l  <= hr_cs_l;
      r_ck    <= hr_ck;
      r_ck_d  <= r_ck;
      r_dq    <= hr_dq_in;
      r_rwds  <= hr_rwds_in;
    end
  end

  logic w_reset, w_rise, w_fall, w_edge;
  assign w_reset = rst | ~r_rst_l;
  assign w_rise  = r_ck & ~r_ck_d;
  assign w_fall  = ~r_ck & r_ck_d;
  assign w_edge  = w_rise | w_fall;

  state_t          r_state, w_state_next;
  logic [39:0]     r_ca;
  logic [CW-1:0]   r_cnt;
  logic            r_is_read, r_is_reg;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_reg_addr;

  // Full CA word as it will look once the current byte is shifted in.
  logic [47:0] w_ca_full;
  logic [31:0] w_addr_full;
  logic        w_ca_done;
  assign w_ca_full   = {r_ca, r_dq};
  assign w_addr_full = {w_ca_full[44:16], w_ca_full[2:0]};
  assign w_ca_done   = w_edge && (r_cnt == CW'(5));

  // Burst type bit and upper address bits beyond the register window are
  // intentionally not decoded.
  logic w_unused;
  assign w_unused = ^{w_ca_full[45], w_addr_full[31:16]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (w_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (r_cs_l) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_CA;
        S_CA: begin
          // Register-space writes carry data right after CA.
          if (w_ca_done)
            w_state_next = (w_ca_full[46] && !w_ca_full[47]) ? S_WRITE : S_LATENCY;
        end
        S_LATENCY: begin
          // Leave on the falling edge after the last counted rising edge so
          // the next rising edge is the first data edge.
          if (w_fall && (r_cnt == CW'(2 * LAT)))
            w_state_next = r_is_read ? S_READ : S_WRITE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // ---------------- Datapath: CA shift, counters, address ----------------
  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_ca       <= '0;
      r_cnt      <= '0;
      r_is_read  <= 1'b0;
      r_is_reg   <= 1'b0;
      r_addr     <= '0;
      r_reg_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ca  <= '0;
          r_cnt <= '0;
        end
        S_CA: begin
          if (w_edge) begin
            r_ca <= w_ca_full[39:0];
            if (w_ca_done) begin
              r_cnt      <= '0;
              r_is_read  <= w_ca_full[47];
              r_is_reg   <= w_ca_full[46];
              r_addr     <= w_addr_full[AW-1:0];
              r_reg_addr <= w_addr_full[15:0];
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LATENCY: begin
          if (w_rise) r_cnt <= r_cnt + CW'(1);
        end
        S_WRITE, S_READ: begin
          if (w_fall && !r_cs_l) begin
            r_addr     <= r_addr + AW'(1);
            r_reg_addr <= r_reg_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- Memory array: two byte lanes ----------------
  // Lane 1 holds word[15:8] (rising edge), lane 0 holds word[7:0] (falling).
  logic        w_wr_ok;
  logic [1:0]  w_we;
  logic [15:0] w_mem_word;
  assign w_wr_ok = (r_state == S_WRITE) && !r_cs_l && !w_reset && !r_rwds;
  assign w_we[1] = w_wr_ok && !r_is_reg && w_rise;
  assign w_we[0] = w_wr_ok && !r_is_reg && w_fall;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;
      // Read every cycle: the word at r_addr is ready one clk after the
      // address moves, well before the next CK edge arrives.
      always_ff @(posedge clk) begin
        if (w_we[gi]) r_mem[r_addr] <= r_dq;
        r_q <= r_mem[r_addr];
      end
      assign w_mem_word[gi*8 +: 8] = r_q;
    end
  endgenerate

  // ---------------- Register space ----------------
  logic [15:0] w_reg_rdata;
`ifdef HYPERRAM_RESP_REGS_EN
  logic [15:0] r_cr0;
  logic        w_cr0_wr;
  assign w_cr0_wr = w_wr_ok && r_is_reg && (r_reg_addr == 16'h0800);

  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_cr0 <= 16'h8F1F;
    end else if (w_cr0_wr) begin
      if (w_rise) r_cr0[15:8] <= r_dq;
      if (w_fall) r_cr0[7:0]  <= r_dq;
    end
  end

  always_comb begin
    case (r_reg_addr)
      16'h0000: w_reg_rdata = 16'h0C81;
      16'h0001: w_reg_rdata = 16'h0001;
      16'h0800: w_reg_rdata = r_cr0;
      default:  w_reg_rdata = 16'h0000;
    endcase
  end
`else
  logic w_unused_reg;
  assign w_reg_rdata  = 16'h0000;
  assign w_unused_reg = ^r_reg_addr;
`endif

  logic [15:0] w_rd_word;
  assign w_rd_word = r_is_reg ? w_reg_rdata : w_mem_word;

  // ---------------- FSM: outputs (registered below) ----------------
  logic [7:0] r_dq_out, w_dq_out_next;
  logic       r_dq_oe_l, w_dq_oe_l_next;
  logic       r_rwds_out, w_rwds_out_next;
  logic       r_rwds_oe_l, w_rwds_oe_l_next;

  always_comb begin
    w_dq_out_next    = r_dq_out;
    w_dq_oe_l_next   = r_dq_oe_l;
    w_rwds_out_next  = r_rwds_out;
    w_rwds_oe_l_next = r_rwds_oe_l;
    if (r_cs_l) begin
      w_dq_oe_l_next   = 1'b1;
      w_rwds_oe_l_next = 1'b1;
      w_rwds_out_next  = 1'b0;
    end else begin
      case (r_state)
        S_CA: begin
          // RWDS high during CA advertises the doubled latency.
          w_dq_oe_l_next   = 1'b1;
          w_rwds_oe_l_next = 1'b0;
          w_rwds_out_next  = 1'b1;
        end
        S_READ: begin
          if (w_rise) begin
            w_dq_out_next    = w_rd_word[15:8];
            w_rwds_out_next  = 1'b1;
            w_dq_oe_l_next   = 1'b0;
            w_rwds_oe_l_next = 1'b0;
          end else if (w_fall) begin
            w_dq_out_next    = w_rd_word[7:0];
            w_rwds_out_next  = 1'b0;
            w_dq_oe_l_next   = 1'b0;
            w_rwds_oe_l_next = 1'b0;
          end
        end
        default: begin
          w_dq_oe_l_next   = 1'b1;
          w_rwds_oe_l_next = 1'b1;
          w_rwds_out_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_dq_out    <= 8'h00;
      r_dq_oe_l   <= 1'b1;
      r_rwds_out  <= 1'b0;
      r_rwds_oe_l <= 1'b1;
    end else begin
      r_dq_out    <= w_dq_out_next;
      r_dq_oe_l   <= w_dq_oe_l_next;
      r_rwds_out  <= w_rwds_out_next;
      r_rwds_oe_l <= w_rwds_oe_l_next;
    end
  end

  assign hr_dq_out    = r_dq_out;
  assign hr_dq_oe_l   = r_dq_oe_l;
  assign hr_rwds_out  = r_rwds_out;
  assign hr_rwds_oe_l = r_rwds_oe_l;

endmodule

// File: tb/tb_hyperram_responder.sv
// tb_hyperram_responder
//   Controller-side bench: drives HyperBus transactions bit-banged in the clk
//   domain into a default (AW=10) responder and an AW=4 responder sharing the
//   bus, and checks results against a word/byte-known reference model.
module tb_hyperram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, hr_rst_l, cs_l, hr_ck, hr_rwds_in, sel;
  logic [7:0] hr_dq_in;
  logic       cs_a, cs_b;
  assign cs_a = sel ? 1'b1 : cs_l;
  assign cs_b = sel ? cs_l : 1'b1;

  logic [7:0] dq_a, dq_b;
  logic       dqoe_a, dqoe_b, rw_a, rw_b, rwoe_a, rwoe_b;
  logic [7:0] dq;
  logic       dqoe, rw, rwoe;
  assign dq   = sel ? dq_b   : dq_a;
  assign dqoe = sel ? dqoe_b : dqoe_a;
  assign rw   = sel ? rw_b   : rw_a;
  assign rwoe = sel ? rwoe_b : rwoe_a;

  hyperram_responder u_dut (
    .clk(clk), .rst(rst), .hr_rst_l(hr_rst_l), .hr_cs_l(cs_a), .hr_ck(hr_ck),
    .hr_dq_in(hr_dq_in), .hr_dq_out(dq_a), .hr_dq_oe_l(dqoe_a),
    .hr_rwds_in(hr_rwds_in), .hr_rwds_out(rw_a), .hr_rwds_oe_l(rwoe_a)
  );

  hyperram_responder #(.AW(4)) u_dut4 (
    .clk(clk), .rst(rst), .hr_rst_l(hr_rst_l), .hr_cs_l(cs_b), .hr_ck(hr_ck),
    .hr_dq_in(hr_dq_in), .hr_dq_out(dq_b), .hr_dq_oe_l(dqoe_b),
    .hr_rwds_in(hr_rwds_in), .hr_rwds_out(rw_b), .hr_rwds_oe_l(rwoe_b)
  );

`ifdef HYPERRAM_RESP_REGS_EN
  localparam logic [15:0] EXP_ID0 = 16'h0C81;
  localparam logic [15:0] EXP_ID1 = 16'h0001;
  localparam logic [15:0] EXP_CR_RST = 16'h8F1F;
  localparam logic [15:0] EXP_CR_NEW = 16'h8F17;
`else
  localparam logic [15:0] EXP_ID0 = 16'h0000;
  localparam logic [15:0] EXP_ID1 = 16'h0000;
  localparam logic [15:0] EXP_CR_RST = 16'h0000;
  localparam logic [15:0] EXP_CR_NEW = 16'h0000;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word contents plus per-byte "known" flags {hi, lo}.
  logic [15:0] model [0:1][0:1023];
  logic [1:0]  kn    [0:1][0:1023];

  logic [15:0] wbuf [0:7];
  logic        mh   [0:7];
  logic        ml   [0:7];
  logic [15:0] rbuf [0:7];

  typedef struct {
    logic [31:0] addr;
    logic [15:0] pre;
    logic [15:0] wr;
    logic        mhi;
    logic        mlo;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic rg, input logic [31:0] a);
    logic [47:0] c;
    c = '0;
    c[47] = rd;
    c[46] = rg;
    c[45] = 1'b1;
    c[44:16] = a[31:3];
    c[2:0] = a[2:0];
    return c;
  endfunction

  // One CK edge: data set up 2 clk ahead, outputs sampled 2 clk after.
  task automatic ck_edge(input logic [7:0] d, input logic m);
    @(negedge clk);
    hr_dq_in = d;
    hr_rwds_in = m;
    @(negedge clk);
    @(negedge clk);
    hr_ck = ~hr_ck;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic start_ca(input logic rd, input logic rg, input logic [31:0] a);
    logic [47:0] c;
    c = make_ca(rd, rg, a);
    @(negedge clk);
    cs_l = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ck_edge(c[47-8*i -: 8], 1'b0);
      if (i == 1) begin
        check("ca_rwds_out", {31'd0, rw}, 32'd1);
        check("ca_rwds_oe_l", {31'd0, rwoe}, 32'd0);
      end
    end
  endtask

  // 2*LAT = 12 CK cycles of latency = 24 edges.
  task automatic latency(input logic rd);
    for (int i = 0; i < 24; i++) ck_edge(8'hA5, 1'b0);
    if (rd) check("lat_dq_oe_l_before_edge16", {31'd0, dqoe}, 32'd1);
  endtask

  task automatic end_cs();
    @(negedge clk);
    cs_l = 1'b1;
    repeat (3) @(negedge clk);
    check("end_dq_oe_l", {31'd0, dqoe}, 32'd1);
    check("end_rwds_oe_l", {31'd0, rwoe}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic int depth();
    return sel ? 16 : 1024;
  endfunction

  task automatic write_burst(input logic [31:0] a, input int n, input logic rg);
    int idx;
    start_ca(1'b0, rg, a);
    if (!rg) latency(1'b0);
    for (int i = 0; i < n; i++) begin
      ck_edge(wbuf[i][15:8], mh[i]);
      ck_edge(wbuf[i][7:0], ml[i]);
    end
    end_cs();
    if (!rg) begin
      for (int i = 0; i < n; i++) begin
        idx = (int'(a) + i) % depth();
        if (!mh[i]) begin model[sel][idx][15:8] = wbuf[i][15:8]; kn[sel][idx][1] = 1'b1; end
        if (!ml[i]) begin model[sel][idx][7:0]  = wbuf[i][7:0];  kn[sel][idx][0] = 1'b1; end
      end
    end
    $display("WR dev=%0d reg=%0d addr=%h n=%0d first=%h", sel, rg, a, n, wbuf[0]);
  endtask

  task automatic read_burst(input logic [31:0] a, input int n, input logic rg);
    start_ca(1'b1, rg, a);
    latency(1'b1);
    for (int i = 0; i < n; i++) begin
      ck_edge(8'h00, 1'b0);
      rbuf[i][15:8] = dq;
      check("rd_rwds_rise", {31'd0, rw}, 32'd1);
      check("rd_dq_oe_l", {31'd0, dqoe}, 32'd0);
      ck_edge(8'h00, 1'b0);
      rbuf[i][7:0] = dq;
      check("rd_rwds_fall", {31'd0, rw}, 32'd0);
      check("rd_rwds_oe_l", {31'd0, rwoe}, 32'd0);
    end
    end_cs();
    $display("RD dev=%0d reg=%0d addr=%h n=%0d first=%h", sel, rg, a, n, rbuf[0]);
  endtask

  task automatic check_model(input string nm, input logic [31:0] a, input int n);
    int idx;
    logic [15:0] m;
    for (int i = 0; i < n; i++) begin
      idx = (int'(a) + i) % depth();
      m = {{8{kn[sel][idx][1]}}, {8{kn[sel][idx][0]}}};
      if (m != 16'h0000)
        check(nm, {16'd0, rbuf[i] & m}, {16'd0, model[sel][idx] & m});
    end
  endtask

  task automatic clr_masks();
    for (int i = 0; i < 8; i++) begin mh[i] = 1'b0; ml[i] = 1'b0; end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] c;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) begin model[d][i] = 16'h0000; kn[d][i] = 2'b00; end

    vt[0] = '{addr: 32'd10,   pre: 16'hFFFF, wr: 16'h1234, mhi: 1'b0, mlo: 1'b1, exp: 16'h12FF};
    vt[1] = '{addr: 32'd11,   pre: 16'h0000, wr: 16'hABCD, mhi: 1'b1, mlo: 1'b0, exp: 16'h00CD};
    vt[2] = '{addr: 32'd12,   pre: 16'h5A5A, wr: 16'h1111, mhi: 1'b1, mlo: 1'b1, exp: 16'h5A5A};
    vt[3] = '{addr: 32'd13,   pre: 16'h5A5A, wr: 16'hC3E1, mhi: 1'b0, mlo: 1'b0, exp: 16'hC3E1};
    vt[4] = '{addr: 32'd1023, pre: 16'h0F0F, wr: 16'h7788, mhi: 1'b0, mlo: 1'b1, exp: 16'h770F};

    sel = 1'b0; cs_l = 1'b1; hr_ck = 1'b0; rst = 1'b1; hr_rst_l = 1'b1;
    hr_dq_in = 8'h00; hr_rwds_in = 1'b0;
    clr_masks();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dq_out", {24'd0, dq}, 32'd0);
    check("rst_dq_oe_l", {31'd0, dqoe}, 32'd1);
    check("rst_rwds_out", {31'd0, rw}, 32'd0);
    check("rst_rwds_oe_l", {31'd0, rwoe}, 32'd1);

    // DEADBEEF at word 4, read back 2 words.
    wbuf[0] = 16'hDEAD; wbuf[1] = 16'hBEEF;
    write_burst(32'd4, 2, 1'b0);
    read_burst(32'd4, 2, 1'b0);
    check("deadbeef", {rbuf[0], rbuf[1]}, 32'hDEADBEEF);

    // Byte-mask vector table.
    for (int v = 0; v < 5; v++) begin
      clr_masks();
      wbuf[0] = vt[v].pre;
      write_burst(vt[v].addr, 1, 1'b0);
      wbuf[0] = vt[v].wr; mh[0] = vt[v].mhi; ml[0] = vt[v].mlo;
      write_burst(vt[v].addr, 1, 1'b0);
      read_burst(vt[v].addr, 1, 1'b0);
      check($sformatf("vec%0d", v), {16'd0, rbuf[0]}, {16'd0, vt[v].exp});
    end
    clr_masks();

    // Write aborted after 4 CA edges, then a clean read of the same word.
    c = make_ca(1'b0, 1'b0, 32'd13);
    @(negedge clk);
    cs_l = 1'b0;
    for (int i = 0; i < 4; i++) ck_edge(c[47-8*i -: 8], 1'b0);
    end_cs();
    $display("WR dev=0 aborted after 4 CA edges addr=0000000d");
    read_burst(32'd13, 1, 1'b0);
    check("abort_no_change", {16'd0, rbuf[0]}, 32'h0000C3E1);

    // Device reset in the middle of CA releases RWDS.
    @(negedge clk);
    cs_l = 1'b0;
    for (int i = 0; i < 3; i++) ck_edge(8'h00, 1'b0);
    check("pre_hrst_rwds_oe_l", {31'd0, rwoe}, 32'd0);
    hr_rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("hrst_rwds_oe_l", {31'd0, rwoe}, 32'd1);
    check("hrst_rwds_out", {31'd0, rw}, 32'd0);
    hr_rst_l = 1'b1;
    ck_edge(8'h00, 1'b0);
    end_cs();
    $display("RST dev=0 hr_rst_l pulse during CA");
    read_burst(32'd4, 2, 1'b0);
    check("post_hrst_read", {rbuf[0], rbuf[1]}, 32'hDEADBEEF);

    // Register space.
    wbuf[0] = 16'h0BAD;
    write_burst(32'd0, 1, 1'b0);
    read_burst(32'd0, 1, 1'b1);
    check("reg_id0", {16'd0, rbuf[0]}, {16'd0, EXP_ID0});
    read_burst(32'h800, 1, 1'b1);
    check("reg_cr0_rst", {16'd0, rbuf[0]}, {16'd0, EXP_CR_RST});
    wbuf[0] = 16'h8F17;
    write_burst(32'h800, 1, 1'b1);
    read_burst(32'h800, 1, 1'b1);
    check("reg_cr0_wr", {16'd0, rbuf[0]}, {16'd0, EXP_CR_NEW});
    read_burst(32'd1, 1, 1'b1);
    check("reg_id1", {16'd0, rbuf[0]}, {16'd0, EXP_ID1});
    read_burst(32'd0, 1, 1'b0);
    check("reg_wr_no_mem", {16'd0, rbuf[0]}, 32'h00000BAD);

    // AW=4 wrap.
    sel = 1'b1;
    wbuf[0] = 16'h1000; wbuf[1] = 16'h1001; wbuf[2] = 16'h1002; wbuf[3] = 16'h1003;
    write_burst(32'd0, 4, 1'b0);
    wbuf[0] = 16'h100F;
    write_burst(32'd15, 1, 1'b0);
    wbuf[0] = 16'hA0A0; wbuf[1] = 16'hB1B1; wbuf[2] = 16'hC2C2;
    write_burst(32'd15, 3, 1'b0);
    read_burst(32'd15, 4, 1'b0);
    check("aw4_w15", {16'd0, rbuf[0]}, 32'h0000A0A0);
    check("aw4_w0",  {16'd0, rbuf[1]}, 32'h0000B1B1);
    check("aw4_w1",  {16'd0, rbuf[2]}, 32'h0000C2C2);
    check("aw4_w2",  {16'd0, rbuf[3]}, 32'h00001002);
    read_burst(32'd3, 1, 1'b0);
    check("aw4_w3", {16'd0, rbuf[0]}, 32'h00001003);

    // Randomized bursts against the model.
    sel = 1'b0;
    for (int it = 0; it < 16; it++) begin
      logic [31:0] a;
      int n;
      a = 32'($urandom_range(0, 1023));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 16'($urandom);
        mh[i] = ($urandom_range(0, 3) == 0);
        ml[i] = ($urandom_range(0, 3) == 0);
      end
      write_burst(a, n, 1'b0);
      read_burst(a, n, 1'b0);
      check_model($sformatf("rand%0d", it), a, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
